// File: rtl/seq_feeder_pkg.sv
// seq_feeder_pkg: shared types for the sequence feeder.
//   - state_t    : feeder FSM encoding (IDLE / SERVE / DONE)
//   - base_t     : 2-bit nucleotide encoding, A/C/G/T = 0..3
//   - col_word_t : one {t, v, f} column word at the default V/F width
// The V/F width comes from the V_E_F_Bit macro; it falls back to 8 when the
// surrounding build does not provide one.
`ifndef V_E_F_Bit
`define V_E_F_Bit 8
`endif

package seq_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  localparam int VEF_W = `V_E_F_Bit;

  typedef struct packed {
    logic [1:0]       t;
    logic [VEF_W-1:0] v;
    logic [VEF_W-1:0] f;
  } col_word_t;

  function automatic col_word_t make_col(input logic [1:0] t,
                                         input logic [VEF_W-1:0] v,
                                         input logic [VEF_W-1:0] f);
    col_word_t w;
    w.t = t;
    w.v = v;
    w.f = f;
    return w;
  endfunction

endpackage

// File: rtl/seq_feeder_tcol_bank.sv
// tcol_bank: one bank of the T/V/F column ping-pong buffer.
// Flop array of DEPTH words, one synchronous write port and one
// asynchronous read port (a write in cycle n is readable in cycle n+1).
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data ({t, v, f} packed)
//   i_raddr  read address
//   o_rdata  read data (combinational from the array)
module tcol_bank
  import seq_feeder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int W     = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/seq_feeder.sv
// seq_feeder: query/database sequence feeder with column write-back buffer.
// The host appends S and T bases in IDLE. On start, S and T are streamed to
// the array controller; the column the array returns after each pass is
// captured into the ping-pong T bank that feeds the following pass.
//
// Handshake: o_data_valid says the current o_s / o_t / o_v / o_f words are
// valid; a beat happens in any cycle where o_data_valid is high and
// i_update_s_w or i_update_t_w is high. Updates while o_data_valid is low
// are ignored. Pointer changes from a beat show up the next cycle.
// Write-back (i_t_valid) has no back-pressure and is accepted only in SERVE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_load_we/sel/base       host append (sel 0 = S, 1 = T)
//   o_load_err               sticky error: overflow, non-IDLE load, bad start
//   i_start, o_busy, o_done  job control
//   o_data_valid             current stream words valid
//   i_update_s_w, o_s, o_s_last
//   i_update_t_w, o_t, o_v, o_f, o_t_last
//   i_t_valid, i_t, i_v, i_f write-back column word
//   o_pass                   current pass index
//   o_stall_cycles           (only with SEQ_FEEDER_STALL_CNT_EN) SERVE cycles
//                            with o_data_valid low since the last start
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int S_MAX_LEN = 1024,
  parameter int T_MAX_LEN = 1024,
  parameter int VEF_BITS  = `V_E_F_Bit
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load_we,
  input  logic                i_load_sel,
  input  logic [1:0]          i_load_base,
  output logic                o_load_err,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_data_valid,
  input  logic                i_update_s_w,
  output logic [1:0]          o_s,
  output logic                o_s_last,
  input  logic                i_update_t_w,
  output logic [1:0]          o_t,
  output logic [VEF_BITS-1:0] o_v,
  output logic [VEF_BITS-1:0] o_f,
  output logic                o_t_last,
  input  logic                i_t_valid,
  input  logic [1:0]          i_t,
  input  logic [VEF_BITS-1:0] i_v,
  input  logic [VEF_BITS-1:0] i_f,
  output logic [15:0]         o_pass
`ifdef SEQ_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]         o_stall_cycles
`endif
);

  localparam int SLW = $clog2(S_MAX_LEN + 1);  // length: 0..MAX
  localparam int SPW = $clog2(S_MAX_LEN);      // array index
  localparam int TLW = $clog2(T_MAX_LEN + 1);
  localparam int TPW = $clog2(T_MAX_LEN);
  localparam int CW  = 2 + 2 * VEF_BITS;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [SLW-1:0] r_s_len;
  logic [TLW-1:0] r_t_len;
  logic [SLW-1:0] r_s_ptr;
  logic [TLW-1:0] r_t_ptr;
  logic           r_rd_bank;
  logic           r_wr_bank;
  logic [TLW-1:0] r_wr_ptr;
  logic [TLW-1:0] r_wr_cnt0;
  logic [TLW-1:0] r_wr_cnt1;
  logic [15:0]    r_pass;
  logic           r_load_err;
  logic [1:0]     r_s_mem [S_MAX_LEN];

  logic           w_idle, w_serve;
  logic [SLW-1:0] w_s_len_m1;
  logic [TLW-1:0] w_t_len_m1;
  logic           w_s_room, w_t_room;
  logic           w_load_s, w_load_t, w_load_bad;
  logic           w_start_ok, w_start_bad;
  logic [TLW-1:0] w_rd_cnt;
  logic           w_data_valid;
  logic           w_beat_s, w_beat_t;
  logic           w_s_at_last, w_t_at_last;
  logic           w_t_wrap, w_finish;
  logic           w_wb, w_wb_last;
  logic           w_b0_we, w_b1_we;
  logic [TPW-1:0] w_b0_waddr;
  logic [CW-1:0]  w_b0_wdata, w_wb_word;
  logic [CW-1:0]  w_b0_rd, w_b1_rd, w_rd_word;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_serve = (r_state == ST_SERVE);

  assign w_s_len_m1 = r_s_len - SLW'(1);
  assign w_t_len_m1 = r_t_len - TLW'(1);
  assign w_s_room   = (r_s_len < SLW'(S_MAX_LEN));
  assign w_t_room   = (r_t_len < TLW'(T_MAX_LEN));

  assign w_load_s   = i_load_we & w_idle & ~i_load_sel & w_s_room;
  assign w_load_t   = i_load_we & w_idle &  i_load_sel & w_t_room;
  assign w_load_bad = i_load_we & (~w_idle | (i_load_sel ? ~w_t_room : ~w_s_room));

  assign w_start_ok  = w_idle & i_start & (r_s_len != '0) & (r_t_len != '0);
  assign w_start_bad = w_idle & i_start & ~w_start_ok;

  // Pass 0 reads the host-loaded bank; later passes stall until the column
  // word at t_ptr has been written back. Uses the registered count, so a
  // write in this cycle only unstalls the next one.
  assign w_rd_cnt     = r_rd_bank ? r_wr_cnt1 : r_wr_cnt0;
  assign w_data_valid = w_serve & ((r_pass == 16'd0) | (r_t_ptr < w_rd_cnt));

  assign w_beat_s    = w_data_valid & i_update_s_w;
  assign w_beat_t    = w_data_valid & i_update_t_w;
  assign w_s_at_last = (r_s_ptr == w_s_len_m1);
  assign w_t_at_last = (r_t_ptr == w_t_len_m1);
  assign w_t_wrap    = w_beat_t & w_t_at_last;
  assign w_finish    = w_t_wrap & w_s_at_last;

  assign w_wb      = w_serve & i_t_valid;
  assign w_wb_last = (r_wr_ptr == w_t_len_m1);
  assign w_wb_word = {i_t, i_v, i_f};

  // Bank 0 is shared by host loading (IDLE) and write-back (SERVE); the two
  // never overlap, so a single write port is enough.
  assign w_b0_we    = w_load_t | (w_wb & ~r_wr_bank);
  assign w_b0_waddr = w_idle ? r_t_len[TPW-1:0] : r_wr_ptr[TPW-1:0];
  assign w_b0_wdata = w_idle ? {i_load_base, {(2*VEF_BITS){1'b0}}} : w_wb_word;
  assign w_b1_we    = w_wb & r_wr_bank;

  tcol_bank #(.DEPTH(T_MAX_LEN), .W(CW), .AW(TPW)) u_bank0 (
    .clk     (clk),
    .i_we    (w_b0_we),
    .i_waddr (w_b0_waddr),
    .i_wdata (w_b0_wdata),
    .i_raddr (r_t_ptr[TPW-1:0]),
    .o_rdata (w_b0_rd)
  );

  tcol_bank #(.DEPTH(T_MAX_LEN), .W(CW), .AW(TPW)) u_bank1 (
    .clk     (clk),
    .i_we    (w_b1_we),
    .i_waddr (r_wr_ptr[TPW-1:0]),
    .i_wdata (w_wb_word),
    .i_raddr (r_t_ptr[TPW-1:0]),
    .o_rdata (w_b1_rd)
  );

  assign w_rd_word = r_rd_bank ? w_b1_rd : w_b0_rd;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_SERVE;
      ST_SERVE: if (w_finish)   w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_s) r_s_mem[r_s_len[SPW-1:0]] <= i_load_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_len    <= '0;
      r_t_len    <= '0;
      r_s_ptr    <= '0;
      r_t_ptr    <= '0;
      r_rd_bank  <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_wr_ptr   <= '0;
      r_wr_cnt0  <= '0;
      r_wr_cnt1  <= '0;
      r_pass     <= '0;
      r_load_err <= 1'b0;
    end else begin
      if (w_load_bad | w_start_bad) r_load_err <= 1'b1;
      if (w_load_s) r_s_len <= r_s_len + SLW'(1);
      if (w_load_t) r_t_len <= r_t_len + TLW'(1);

      if (w_start_ok) begin
        r_s_ptr   <= '0;
        r_t_ptr   <= '0;
        r_rd_bank <= 1'b0;
        r_wr_bank <= 1'b1;
        r_wr_ptr  <= '0;
        r_wr_cnt1 <= '0;
        r_wr_cnt0 <= r_t_len;
        r_pass    <= '0;
      end else begin
        // S saturates on its last base so it can be re-read every pass
        if (w_beat_s && !w_s_at_last) r_s_ptr <= r_s_ptr + SLW'(1);

        if (w_beat_t) begin
          if (w_t_at_last) begin
            r_t_ptr   <= '0;
            r_rd_bank <= ~r_rd_bank;
            r_pass    <= r_pass + 16'd1;
          end else begin
            r_t_ptr <= r_t_ptr + TLW'(1);
          end
        end

        if (w_wb) begin
          if (r_wr_bank) r_wr_cnt1 <= r_wr_cnt1 + TLW'(1);
          else           r_wr_cnt0 <= r_wr_cnt0 + TLW'(1);
          if (w_wb_last) begin
            r_wr_ptr  <= '0;
            r_wr_bank <= ~r_wr_bank;
            // clear the bank we are about to start filling
            if (r_wr_bank) r_wr_cnt0 <= '0;
            else           r_wr_cnt1 <= '0;
          end else begin
            r_wr_ptr <= r_wr_ptr + TLW'(1);
          end
        end
      end
    end
  end

`ifdef SEQ_FEEDER_STALL_CNT_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk) begin
    if (rst)                          r_stall_cycles <= '0;
    else if (w_start_ok)              r_stall_cycles <= '0;
    else if (w_serve & ~w_data_valid) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign o_stall_cycles = r_stall_cycles;
`endif

  // Data outputs are forced to zero outside SERVE so reset and idle look clean
  assign o_load_err   = r_load_err;
  assign o_busy       = ~w_idle;
  assign o_done       = (r_state == ST_DONE);
  assign o_data_valid = w_data_valid;
  assign o_s          = w_serve ? r_s_mem[r_s_ptr[SPW-1:0]] : 2'b00;
  assign o_s_last     = w_serve & w_s_at_last;
  assign o_t          = w_serve ? w_rd_word[CW-1 -: 2] : 2'b00;
  assign o_v          = w_serve ? w_rd_word[2*VEF_BITS-1 -: VEF_BITS] : '0;
  assign o_f          = w_serve ? w_rd_word[VEF_BITS-1:0] : '0;
  assign o_t_last     = w_serve & w_t_at_last;
  assign o_pass       = r_pass;

endmodule

// File: tb/tb_seq_feeder.sv
// Self-checking bench for seq_feeder: table-driven main job, stall/restart,
// load error and reset corner sequences. Expected column words are queued
// when loaded or written back and popped on every T beat.
`ifndef V_E_F_Bit
`define V_E_F_Bit 8
`endif

module tb_seq_feeder;
  import seq_feeder_pkg::*;

  localparam int VB = VEF_W;
  localparam int CW = $bits(col_word_t);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_load_we, i_load_sel;
  logic [1:0]    i_load_base;
  logic          o_load_err;
  logic          i_start, o_busy, o_done, o_data_valid;
  logic          i_update_s_w, i_update_t_w;
  logic [1:0]    o_s, o_t;
  logic          o_s_last, o_t_last;
  logic [VB-1:0] o_v, o_f;
  logic          i_t_valid;
  logic [1:0]    i_t;
  logic [VB-1:0] i_v, i_f;
  logic [15:0]   o_pass;
`ifdef SEQ_FEEDER_STALL_CNT_EN
  logic [31:0]   o_stall_cycles;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seq_feeder #(.S_MAX_LEN(1024), .T_MAX_LEN(1024), .VEF_BITS(VB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_we    (i_load_we),
    .i_load_sel   (i_load_sel),
    .i_load_base  (i_load_base),
    .o_load_err   (o_load_err),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_data_valid (o_data_valid),
    .i_update_s_w (i_update_s_w),
    .o_s          (o_s),
    .o_s_last     (o_s_last),
    .i_update_t_w (i_update_t_w),
    .o_t          (o_t),
    .o_v          (o_v),
    .o_f          (o_f),
    .o_t_last     (o_t_last),
    .i_t_valid    (i_t_valid),
    .i_t          (i_t),
    .i_v          (i_v),
    .i_f          (i_f),
    .o_pass       (o_pass)
`ifdef SEQ_FEEDER_STALL_CNT_EN
    ,
    .o_stall_cycles (o_stall_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [CW-1:0] w;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0h expected <empty queue>", name, {o_t, o_v, o_f});
    end else begin
      w = exp_q.pop_front();
      chk(name, 64'({o_t, o_v, o_f}), 64'(w));
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({o_load_err, o_busy, o_done, o_data_valid, o_s, o_s_last,
                   o_t, o_v, o_f, o_t_last, o_pass}), 64'd0);
`ifdef SEQ_FEEDER_STALL_CNT_EN
    chk({name, "_stall"}, 64'(o_stall_cycles), 64'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_load_we = 0; i_load_sel = 0; i_load_base = 0; i_start = 0;
    i_update_s_w = 0; i_update_t_w = 0;
    i_t_valid = 0; i_t = 0; i_v = 0; i_f = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input logic sel, input logic [1:0] b);
    i_load_we = 1; i_load_sel = sel; i_load_base = b;
    tick();
    i_load_we = 0;
    if (sel) exp_q.push_back({b, VB'(0), VB'(0)});
  endtask

  task automatic start_job();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic drive_wb(input int k);
    i_t_valid = 1;
    i_t = 2'(3 - k);
    i_v = VB'(10 + k);
    i_f = VB'(20 + k);
    exp_q.push_back({i_t, i_v, i_f});
  endtask

  // ---------------- main-job vector table ----------------
  typedef struct {
    logic        wb;
    int          wb_k;
    logic        exp_valid;
    logic [1:0]  exp_s;
    logic        exp_s_last;
    logic        exp_t_last;
    logic [15:0] exp_pass;
  } vec_t;

  function automatic vec_t mk(input logic wb, input int k, input logic v,
                              input logic [1:0] s, input logic sl,
                              input logic tl, input logic [15:0] p);
    vec_t r;
    r.wb = wb; r.wb_k = k; r.exp_valid = v; r.exp_s = s;
    r.exp_s_last = sl; r.exp_t_last = tl; r.exp_pass = p;
    return r;
  endfunction

  vec_t tbl[6];
  logic [1:0] s_seq[4];
  logic [1:0] t_seq[3];

  initial begin
    s_seq = '{BASE_A, BASE_C, BASE_G, BASE_T};
    t_seq = '{BASE_G, BASE_A, BASE_T};
    // S=ACGT, T=GAT, both consumed every cycle, write-back 2 cycles late
    tbl[0] = mk(0, 0, 1, 2'd0, 0, 0, 16'd0);
    tbl[1] = mk(0, 0, 1, 2'd1, 0, 0, 16'd0);
    tbl[2] = mk(1, 0, 1, 2'd2, 0, 1, 16'd0);
    tbl[3] = mk(1, 1, 1, 2'd3, 1, 0, 16'd1);
    tbl[4] = mk(1, 2, 1, 2'd3, 1, 0, 16'd1);
    tbl[5] = mk(0, 0, 1, 2'd3, 1, 1, 16'd1);

    idle_inputs();
    do_reset();
    chk_zero("reset_state");

    // ---- main job ----
    for (int i = 0; i < 4; i++) load(1'b0, s_seq[i]);
    for (int i = 0; i < 3; i++) load(1'b1, t_seq[i]);
    chk("busy_before_start", 64'(o_busy), 64'd0);
    start_job();
    chk("busy_after_start", 64'(o_busy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("m%0d_valid", i), 64'(o_data_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("m%0d_s", i), 64'(o_s), 64'(tbl[i].exp_s));
      chk($sformatf("m%0d_s_last", i), 64'(o_s_last), 64'(tbl[i].exp_s_last));
      chk($sformatf("m%0d_t_last", i), 64'(o_t_last), 64'(tbl[i].exp_t_last));
      chk($sformatf("m%0d_pass", i), 64'(o_pass), 64'(tbl[i].exp_pass));
      if (tbl[i].exp_valid) sb_check($sformatf("m%0d_tvf", i));
      i_update_s_w = 1; i_update_t_w = 1;
      if (tbl[i].wb) drive_wb(tbl[i].wb_k);
      tick();
      idle_inputs();
    end
    chk("m_done", 64'({o_done, o_busy}), 64'b11);
    chk("m_pass_end", 64'(o_pass), 64'd2);
    tick();
    chk("m_idle", 64'({o_done, o_busy}), 64'b00);
    chk("m_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---- restart with a 5-cycle write-back gap in pass 1 ----
    for (int i = 0; i < 3; i++) exp_q.push_back({t_seq[i], VB'(0), VB'(0)});
    start_job();
    for (int c = 0; c < 11; c++) begin
      logic ev;
      ev = (c < 3) || (c >= 8);
      chk($sformatf("st%0d_valid", c), 64'(o_data_valid), 64'(ev));
      if (ev) sb_check($sformatf("st%0d_tvf", c));
`ifdef SEQ_FEEDER_STALL_CNT_EN
      if (c == 8) chk("st_stall_cnt", 64'(o_stall_cycles), 64'd5);
`endif
      // updates are held high through the stall; they must be ignored
      i_update_s_w = 1; i_update_t_w = 1;
      if (c >= 7 && c <= 9) drive_wb(c - 7);
      tick();
      idle_inputs();
    end
    chk("st_done", 64'(o_done), 64'd1);
`ifdef SEQ_FEEDER_STALL_CNT_EN
    chk("st_stall_done", 64'(o_stall_cycles), 64'd5);
`endif
    tick();
    chk("st_idle", 64'({o_done, o_busy}), 64'b00);
`ifdef SEQ_FEEDER_STALL_CNT_EN
    chk("st_stall_hold", 64'(o_stall_cycles), 64'd5);
`endif

    // ---- start with T_len = 0 ----
    do_reset();
    load(1'b0, BASE_C);
    chk("t0_err_before", 64'(o_load_err), 64'd0);
    start_job();
    chk("t0_busy", 64'({o_busy, o_data_valid}), 64'b00);
    chk("t0_err", 64'(o_load_err), 64'd1);

    // ---- load during SERVE is dropped ----
    do_reset();
    load(1'b0, BASE_G);
    load(1'b1, BASE_C);
    start_job();
    chk("ls_valid", 64'({o_data_valid, o_s_last}), 64'b11);
    i_load_we = 1; i_load_sel = 0; i_load_base = BASE_T;
    tick();
    idle_inputs();
    chk("ls_err", 64'(o_load_err), 64'd1);
    chk("ls_s_last_kept", 64'({o_s, o_s_last, o_t_last}), 64'({2'(BASE_G), 1'b1, 1'b1}));
    sb_check("ls_tvf");
    i_update_s_w = 1; i_update_t_w = 1;
    tick();
    idle_inputs();
    chk("ls_done", 64'(o_done), 64'd1);

    // ---- S overflow: 1025 loads keep S_len at 1024 ----
    do_reset();
    for (int i = 0; i < 1024; i++) load(1'b0, 2'(i % 4));
    chk("ov_err_at_max", 64'(o_load_err), 64'd0);
    load(1'b0, 2'd3);
    chk("ov_err", 64'(o_load_err), 64'd1);
    load(1'b1, BASE_T);
    start_job();
    for (int i = 0; i < 1024; i++) begin
      chk($sformatf("ov%0d_s_last", i), 64'(o_s_last), 64'(i == 1023));
      if (i % 256 == 0 || i == 1023) chk($sformatf("ov%0d_s", i), 64'(o_s), 64'(i % 4));
      if (i == 1023) sb_check("ov_tvf");
      i_update_s_w = 1; i_update_t_w = (i == 1023);
      tick();
      idle_inputs();
    end
    chk("ov_done", 64'(o_done), 64'd1);

    // ---- reset mid-SERVE ----
    do_reset();
    load(1'b0, BASE_A); load(1'b0, BASE_C);
    load(1'b1, BASE_G); load(1'b1, BASE_T);
    start_job();
    i_update_s_w = 1; i_update_t_w = 1;
    tick();
    idle_inputs();
    chk("mr_serving", 64'({o_busy, o_data_valid}), 64'b11);
    do_reset();
    chk_zero("mr_reset_zero");
    start_job();
    chk("mr_len_cleared", 64'({o_busy, o_load_err}), 64'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
